// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-requester DRAM arbiter.
// Read tags carry {valid, requester id} alongside the RAM read pipeline.
package dram_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic {
        REQ1 = 1'b0,
        REQ2 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    // Out-of-range latencies are pulled into the supported window.
    function automatic int clamp_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/dram_arb_if.sv
// Requester-side access bus: request/write fields in, accept pulse and read return out.
interface dram_arb_if
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dram_arb_rr.sv
// Two-way picker: round-robin on last grant, or fixed priority to requester 1
// when DRAM_ARB_FIXED_PRIO_EN is defined.
module dram_arb_rr
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifndef DRAM_ARB_FIXED_PRIO_EN
    input  req_id_t    last_gnt,
`endif
    output logic [1:0] gnt
);

`ifdef DRAM_ARB_FIXED_PRIO_EN
    assign gnt = {req[1] & ~req[0], req[0]};
`else
    // On a tie the side that was not served last wins.
    assign gnt[0] = req[0] & (~req[1] | (last_gnt == REQ2));
    assign gnt[1] = req[1] & (~req[0] | (last_gnt == REQ1));
`endif

endmodule

// File: rtl/dram_arbiter.sv
// Shared single-port DRAM arbiter/sequencer for two requesters.
// Optional DRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    dram_arb_if.slave         p1,
    dram_arb_if.slave         p2,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam int LAT = clamp_lat(RD_LAT);

    logic [1:0]        req;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_data;
    rd_tag_t [LAT:0]   tags;
    logic              in_flight;
    logic              ret1, ret2;
    logic              rvalid1, rvalid2;
    logic [DATA_W-1:0] rdata1, rdata2;

    assign req = {p2.req, p1.req};

`ifdef DRAM_ARB_FIXED_PRIO_EN
    dram_arb_rr u_pick (.req(req), .gnt(pick));
`else
    req_id_t last_gnt;

    dram_arb_rr u_pick (.req(req), .last_gnt(last_gnt), .gnt(pick));

    always_ff @(posedge clk) begin
        if (rst)         last_gnt <= REQ2;
        else if (gnt[0]) last_gnt <= REQ1;
        else if (gnt[1]) last_gnt <= REQ2;
    end
`endif

    assign gnt    = rst ? 2'b00 : pick;
    assign p1.gnt = gnt[0];
    assign p2.gnt = gnt[1];

    assign issue_we   = gnt[1] ? p2.we    : p1.we;
    assign issue_addr = gnt[1] ? p2.addr  : p1.addr;
    assign issue_data = gnt[1] ? p2.wdata : p1.wdata;

    // Address/data hold through idle cycles; only the write strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr <= '0;
            ram_wren <= 1'b0;
            ram_data <= '0;
        end else if (|gnt) begin
            ram_addr <= issue_addr;
            ram_wren <= issue_we;
            ram_data <= issue_data;
        end else begin
            ram_wren <= 1'b0;
        end
    end

    // tags[k] is live k+1 cycles after the grant; tags[LAT] lines up with ram_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            tags <= '0;
        end else begin
            tags[0].valid <= (|gnt) & ~issue_we;
            tags[0].id    <= gnt[1] ? REQ2 : REQ1;
            for (int i = 1; i <= LAT; i++) tags[i] <= tags[i-1];
        end
    end

    assign ret1 = tags[LAT].valid & (tags[LAT].id == REQ1);
    assign ret2 = tags[LAT].valid & (tags[LAT].id == REQ2);

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid1 <= 1'b0;
            rvalid2 <= 1'b0;
            rdata1  <= '0;
            rdata2  <= '0;
        end else begin
            rvalid1 <= ret1;
            rvalid2 <= ret2;
            if (ret1) rdata1 <= ram_q;
            if (ret2) rdata2 <= ram_q;
        end
    end

    assign p1.rvalid = rvalid1;
    assign p1.rdata  = rdata1;
    assign p2.rvalid = rvalid2;
    assign p2.rdata  = rdata2;

    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i <= LAT; i++) in_flight = in_flight | tags[i].valid;
    end

    assign busy = ~rst & ((|req) | in_flight);

endmodule
